// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the
// IF/ID pipeline register, honouring stalls and branch/jump redirects from ID.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_br,
    input  logic [15:0] br_imm,
    input  logic        redirect_j,
    input  logic [25:0] j_index,
    input  logic [31:0] im_instr,
    output logic [31:0] im_addr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    // Word alignment is forced so a misaligned parameter cannot leak into the PC.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_reg;
    logic [31:0] id_instr_reg;
    logic [31:0] id_pc4_reg;
    logic        id_valid_reg;
    logic [31:0] fetch_count_reg;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        take_j;
    logic        take_br;

    // Branch offset is the immediate sign-extended and scaled by 4.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_br_offset
            if (gi < 2) begin : g_zero
                assign br_offset[gi] = 1'b0;
            end else if (gi < 18) begin : g_imm
                assign br_offset[gi] = br_imm[gi-2];
            end else begin : g_sign
                assign br_offset[gi] = br_imm[15];
            end
        end
    endgenerate

    assign pc_plus4  = pc_reg + 32'd4;
    assign br_target = id_pc4_reg + br_offset;
    assign j_target  = {id_pc4_reg[31:28], j_index, 2'b00};

    // A redirect only means something when ID actually holds an instruction.
    assign take_j  = id_valid_reg && redirect_j;
    assign take_br = id_valid_reg && redirect_br;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC_ALIGNED;
            id_instr_reg    <= 32'd0;
            id_pc4_reg      <= 32'd0;
            id_valid_reg    <= 1'b0;
            fetch_count_reg <= 32'd0;
        end else if (take_j) begin
            pc_reg       <= j_target;
            id_instr_reg <= 32'd0;
            id_valid_reg <= 1'b0;
        end else if (take_br) begin
            pc_reg       <= br_target;
            id_instr_reg <= 32'd0;
            id_valid_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg          <= pc_plus4;
            id_instr_reg    <= im_instr;
            id_pc4_reg      <= pc_plus4;
            id_valid_reg    <= 1'b1;
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

    assign im_addr     = pc_reg;
    assign id_instr    = id_instr_reg;
    assign id_pc4      = id_pc4_reg;
    assign id_valid    = id_valid_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios against hand-derived constants, then
// randomized traffic against a transaction-level model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0003;
    localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_br = 1'b0;
    logic [15:0] br_imm = 16'd0;
    logic        redirect_j = 1'b0;
    logic [25:0] j_index = 26'd0;
    logic [31:0] im_instr;
    logic [31:0] im_addr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;
    int edge_num = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    if_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_br(redirect_br), .br_imm(br_imm),
        .redirect_j(redirect_j), .j_index(j_index),
        .im_instr(im_instr), .im_addr(im_addr),
        .id_instr(id_instr), .id_pc4(id_pc4),
        .id_valid(id_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    assign im_instr = imem(im_addr);

    // Model: what the stage must do on one edge, from the rules of the fetch stage.
    task automatic model_update();
        logic [31:0] offset;
        offset = 32'($signed(br_imm)) * 32'd4;
        if (rst) begin
            m_pc = TB_RESET_PC & ~32'd3;
            m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        end else if (m_valid && redirect_j) begin
            m_pc = {m_pc4[31:28], j_index, 2'b00};
            m_instr = 0; m_valid = 0;
        end else if (m_valid && redirect_br) begin
            m_pc = m_pc4 + offset;
            m_instr = 0; m_valid = 0;
        end else if (!stall) begin
            m_instr = imem(m_pc);
            m_pc = m_pc + 4;
            m_pc4 = m_pc;
            m_valid = 1;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic do_edge();
        model_update();
        @(posedge clk);
        #1;
        edge_num++;
        $display("edge %0d rst=%0b stall=%0b br=%0b j=%0b -> im_addr=%h id_pc4=%h id_valid=%0b cnt=%0d",
                 edge_num, rst, stall, redirect_br, redirect_j, im_addr, id_pc4, id_valid, fetch_count);
    endtask

    task automatic clear_inputs();
        rst = 0; stall = 0; redirect_br = 0; redirect_j = 0; br_imm = 0; j_index = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        do_edge();
        do_edge();
        rst = 0;
        checks++; if (im_addr !== EXP_RESET_PC) begin failures++; $display("FAIL reset_im_addr got=%h exp=%h", im_addr, EXP_RESET_PC); end
        checks++; if (id_instr !== 32'd0) begin failures++; $display("FAIL reset_id_instr got=%h exp=0", id_instr); end
        checks++; if (id_pc4 !== 32'd0) begin failures++; $display("FAIL reset_id_pc4 got=%h exp=0", id_pc4); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            do_edge();
            checks++; if (im_addr !== 32'(4 * i)) begin failures++; $display("FAIL seq_im_addr[%0d] got=%h exp=%h", i, im_addr, 32'(4 * i)); end
            checks++; if (id_pc4 !== 32'(4 * i)) begin failures++; $display("FAIL seq_id_pc4[%0d] got=%h exp=%h", i, id_pc4, 32'(4 * i)); end
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL seq_id_valid[%0d] got=%b exp=1", i, id_valid); end
            checks++; if (id_instr !== imem(32'(4 * (i - 1)))) begin failures++; $display("FAIL seq_id_instr[%0d] got=%h exp=%h", i, id_instr, imem(32'(4 * (i - 1)))); end
        end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_stall();
        do_edge(); // PC 0x0C -> 0x10
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            do_edge();
            checks++; if (im_addr !== 32'h10) begin failures++; $display("FAIL stall_im_addr[%0d] got=%h exp=10", i, im_addr); end
            checks++; if (id_pc4 !== 32'h10 || id_instr !== imem(32'h0C) || id_valid !== 1'b1) begin
                failures++; $display("FAIL stall_ifid[%0d] got pc4=%h instr=%h v=%b exp pc4=10 instr=%h v=1", i, id_pc4, id_instr, id_valid, imem(32'h0C)); end
            checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=4", i, fetch_count); end
        end
        stall = 0;
        do_edge();
        checks++; if (im_addr !== 32'h14) begin failures++; $display("FAIL stall_release got=%h exp=14", im_addr); end
        checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL stall_release_count got=%0d exp=5", fetch_count); end
    endtask

    task automatic test_branch();
        do_edge(); do_edge(); do_edge(); // PC -> 0x20, id_pc4 = 0x20
        redirect_br = 1; br_imm = 16'hFFFE;
        do_edge();
        checks++; if (im_addr !== 32'h18) begin failures++; $display("FAIL br_target got=%h exp=18", im_addr); end
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'd0) begin failures++; $display("FAIL br_bubble got v=%b instr=%h exp v=0 instr=0", id_valid, id_instr); end
        checks++; if (id_pc4 !== 32'h20 || fetch_count !== 32'd8) begin failures++; $display("FAIL br_hold got pc4=%h cnt=%0d exp pc4=20 cnt=8", id_pc4, fetch_count); end
        // Branch still asserted but ID is a bubble: must be ignored.
        do_edge();
        checks++; if (im_addr !== 32'h1C) begin failures++; $display("FAIL br_unqualified got=%h exp=1c", im_addr); end
        checks++; if (id_valid !== 1'b1 || id_instr !== imem(32'h18)) begin failures++; $display("FAIL br_target_valid got v=%b instr=%h exp v=1 instr=%h", id_valid, id_instr, imem(32'h18)); end
        redirect_br = 0; br_imm = 0;
    endtask

    task automatic test_jump();
        do_edge(); do_edge(); // PC 0x24, id_pc4 0x24
        redirect_j = 1; j_index = 26'd0; redirect_br = 1; br_imm = 16'h0004; stall = 1;
        do_edge();
        checks++; if (im_addr !== 32'h0) begin failures++; $display("FAIL jump_wins got=%h exp=0", im_addr); end
        checks++; if (id_valid !== 1'b0 || id_pc4 !== 32'h24 || fetch_count !== 32'd11) begin
            failures++; $display("FAIL jump_bubble got v=%b pc4=%h cnt=%0d exp v=0 pc4=24 cnt=11", id_valid, id_pc4, fetch_count); end
        clear_inputs();
        do_edge();
        checks++; if (im_addr !== 32'h4 || id_valid !== 1'b1 || id_instr !== imem(32'h0)) begin
            failures++; $display("FAIL jump_after got addr=%h v=%b instr=%h exp addr=4 v=1 instr=%h", im_addr, id_valid, id_instr, imem(32'h0)); end
    endtask

    task automatic test_reset_override();
        for (int i = 0; i < 6; i++) do_edge(); // PC 0x04 -> 0x1C
        checks++; if (im_addr !== 32'h1C) begin failures++; $display("FAIL rst_setup got=%h exp=1c", im_addr); end
        rst = 1; stall = 1; redirect_j = 1; j_index = 26'h155_5555;
        do_edge();
        checks++; if (im_addr !== EXP_RESET_PC || id_valid !== 1'b0 || fetch_count !== 32'd0 || id_pc4 !== 32'd0) begin
            failures++; $display("FAIL rst_override got addr=%h v=%b cnt=%0d pc4=%h exp addr=%h v=0 cnt=0 pc4=0", im_addr, id_valid, fetch_count, id_pc4, EXP_RESET_PC); end
        clear_inputs();
        do_edge();
        checks++; if (im_addr !== 32'h4 || id_instr !== imem(EXP_RESET_PC) || fetch_count !== 32'd1) begin
            failures++; $display("FAIL rst_resume got addr=%h instr=%h cnt=%0d exp addr=4 instr=%h cnt=1", im_addr, id_instr, fetch_count, imem(EXP_RESET_PC)); end
    endtask

    task automatic test_wrap();
        // From PC=0x4 (id_pc4=0x4): branch -8 lands on the last word.
        redirect_br = 1; br_imm = 16'hFFFE;
        do_edge();
        checks++; if (im_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_target got=%h exp=fffffffc", im_addr); end
        clear_inputs();
        do_edge();
        checks++; if (im_addr !== 32'h0 || id_pc4 !== 32'h0 || id_instr !== imem(32'hFFFF_FFFC)) begin
            failures++; $display("FAIL wrap_pc got addr=%h pc4=%h instr=%h exp addr=0 pc4=0 instr=%h", im_addr, id_pc4, id_instr, imem(32'hFFFF_FFFC)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect_br = ($urandom_range(0, 4) == 0);
            redirect_j  = ($urandom_range(0, 6) == 0);
            br_imm      = 16'($urandom);
            j_index     = 26'($urandom);
            do_edge();
            checks++;
            if (im_addr !== m_pc || id_instr !== m_instr || id_pc4 !== m_pc4 ||
                id_valid !== m_valid || fetch_count !== m_cnt) begin
                failures++;
                $display("FAIL random[%0d] got addr=%h instr=%h pc4=%h v=%b cnt=%0d exp addr=%h instr=%h pc4=%h v=%b cnt=%0d",
                         i, im_addr, id_instr, id_pc4, id_valid, fetch_count, m_pc, m_instr, m_pc4, m_valid, m_cnt);
            end
            checks++;
            if (im_addr[1:0] !== 2'b00) begin failures++; $display("FAIL random_align[%0d] got=%h", i, im_addr); end
        end
        clear_inputs();
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_reset_override();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
